// File: rtl/l2_tlb_miss_ctrl_if.sv
// Bus bundle for the L2 TLB miss controller: L1 request, L2 array lookup,
// page-table-walker request/response, L2 refill write port, sfence, status.
// The slave modport is the controller's view; master is the environment's.
interface l2_tlb_miss_ctrl_if;
  logic        io_req_valid;
  logic        io_req_ready;
  logic [26:0] io_req_vpn;

  logic        l2_lookup_valid;
  logic [26:0] l2_lookup_vpn;
  logic        l2_lookup_hit;

  logic        L2_tlb_miss;

  logic        io_ptw_req_valid;
  logic        io_ptw_req_ready;
  logic [26:0] io_ptw_req_bits_addr;

  logic        io_ptw_resp_valid;
  logic        io_ptw_resp_bits_pte_v;
  logic        io_ptw_resp_bits_pte_u;
  logic        io_ptw_resp_bits_pte_w;
  logic        io_ptw_resp_bits_pte_x;
  logic        io_ptw_resp_bits_pte_r;
  logic        io_ptw_resp_bits_pte_d;
  logic [19:0] io_ptw_resp_bits_pte_ppn;

  logic        l2_refill_valid;
  logic [26:0] l2_refill_vpn;
  logic [19:0] l2_refill_ppn;
  logic        l2_refill_v;
  logic        l2_refill_u;
  logic        l2_refill_w;
  logic        l2_refill_x;
  logic        l2_refill_r;
  logic        l2_refill_d;

  logic        io_invalidate;
  logic        io_busy;

  modport slave (
    input  io_req_valid, io_req_vpn, l2_lookup_hit, io_ptw_req_ready,
           io_ptw_resp_valid, io_ptw_resp_bits_pte_v, io_ptw_resp_bits_pte_u,
           io_ptw_resp_bits_pte_w, io_ptw_resp_bits_pte_x, io_ptw_resp_bits_pte_r,
           io_ptw_resp_bits_pte_d, io_ptw_resp_bits_pte_ppn, io_invalidate,
    output io_req_ready, l2_lookup_valid, l2_lookup_vpn, L2_tlb_miss,
           io_ptw_req_valid, io_ptw_req_bits_addr, l2_refill_valid, l2_refill_vpn,
           l2_refill_ppn, l2_refill_v, l2_refill_u, l2_refill_w, l2_refill_x,
           l2_refill_r, l2_refill_d, io_busy
  );

  modport master (
    output io_req_valid, io_req_vpn, l2_lookup_hit, io_ptw_req_ready,
           io_ptw_resp_valid, io_ptw_resp_bits_pte_v, io_ptw_resp_bits_pte_u,
           io_ptw_resp_bits_pte_w, io_ptw_resp_bits_pte_x, io_ptw_resp_bits_pte_r,
           io_ptw_resp_bits_pte_d, io_ptw_resp_bits_pte_ppn, io_invalidate,
    input  io_req_ready, l2_lookup_valid, l2_lookup_vpn, L2_tlb_miss,
           io_ptw_req_valid, io_ptw_req_bits_addr, l2_refill_valid, l2_refill_vpn,
           l2_refill_ppn, l2_refill_v, l2_refill_u, l2_refill_w, l2_refill_x,
           l2_refill_r, l2_refill_d, io_busy
  );
endinterface

// File: rtl/l2_tlb_miss_ctrl.sv
// L2 TLB miss controller: looks a request up in the L2 array, walks the page
// table on a miss and writes the walker's PTE back into the L2 array.
// Optional feature: define L2_TLB_PERF_CNT_EN to add saturating 32-bit
// hit/miss performance counters (perf_hit_cnt, perf_miss_cnt).
module l2_tlb_miss_ctrl (
  input  logic              clk,
  input  logic              reset,
`ifdef L2_TLB_PERF_CNT_EN
  output logic [31:0]       perf_hit_cnt,
  output logic [31:0]       perf_miss_cnt,
`endif
  l2_tlb_miss_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOOKUP, PTW_REQ, PTW_WAIT, REFILL} state_t;

  state_t      state, state_nxt;
  logic [26:0] vpn_q;
  logic [19:0] ppn_q;
  logic        pte_v_q, pte_u_q, pte_w_q, pte_x_q, pte_r_q, pte_d_q;
  logic        kill_q;
  logic        miss_q;
  logic        req_fire;
  logic        lookup_hit_evt;
  logic        lookup_miss_evt;
  logic        resp_take;

  // Accepting a request while an sfence is asserted would lose it to the abort,
  // so ready is withheld for that cycle.
  assign bus.io_req_ready = (state == IDLE) && !bus.io_invalidate;
  assign req_fire         = bus.io_req_valid && bus.io_req_ready;
  assign lookup_hit_evt   = (state == LOOKUP) && !bus.io_invalidate && bus.l2_lookup_hit;
  assign lookup_miss_evt  = (state == LOOKUP) && !bus.io_invalidate && !bus.l2_lookup_hit;
  assign resp_take        = (state == PTW_WAIT) && bus.io_ptw_resp_valid;

  assign bus.l2_lookup_valid      = req_fire;
  assign bus.l2_lookup_vpn        = req_fire ? bus.io_req_vpn : '0;
  assign bus.L2_tlb_miss          = miss_q;
  assign bus.io_ptw_req_valid     = (state == PTW_REQ);
  assign bus.io_ptw_req_bits_addr = vpn_q;
  assign bus.io_busy              = (state != IDLE);
  assign bus.l2_refill_valid      = (state == REFILL) && pte_v_q && !kill_q;
  assign bus.l2_refill_vpn        = vpn_q;
  assign bus.l2_refill_ppn        = ppn_q;
  assign bus.l2_refill_v          = pte_v_q;
  assign bus.l2_refill_u          = pte_u_q;
  assign bus.l2_refill_w          = pte_w_q;
  assign bus.l2_refill_x          = pte_x_q;
  assign bus.l2_refill_r          = pte_r_q;
  assign bus.l2_refill_d          = pte_d_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_fire) state_nxt = LOOKUP;
      LOOKUP:   state_nxt = lookup_miss_evt ? PTW_REQ : IDLE;
      PTW_REQ:  if (bus.io_ptw_req_ready) state_nxt = PTW_WAIT;
      PTW_WAIT: if (bus.io_ptw_resp_valid) state_nxt = REFILL;
      REFILL:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Transaction context: request VPN, captured PTE, miss and kill flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpn_q   <= '0;
      ppn_q   <= '0;
      pte_v_q <= 1'b0;
      pte_u_q <= 1'b0;
      pte_w_q <= 1'b0;
      pte_x_q <= 1'b0;
      pte_r_q <= 1'b0;
      pte_d_q <= 1'b0;
      kill_q  <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      if (req_fire) vpn_q <= bus.io_req_vpn;
      if (resp_take) begin
        ppn_q   <= bus.io_ptw_resp_bits_pte_ppn;
        pte_v_q <= bus.io_ptw_resp_bits_pte_v;
        pte_u_q <= bus.io_ptw_resp_bits_pte_u;
        pte_w_q <= bus.io_ptw_resp_bits_pte_w;
        pte_x_q <= bus.io_ptw_resp_bits_pte_x;
        pte_r_q <= bus.io_ptw_resp_bits_pte_r;
        pte_d_q <= bus.io_ptw_resp_bits_pte_d;
      end
      // Miss stays high through REFILL so the arbiter forwards the walker data.
      if (state == LOOKUP)                     miss_q <= lookup_miss_evt;
      else if (state == REFILL || state == IDLE) miss_q <= 1'b0;
      // An sfence during the walk lets it finish but blocks the array write.
      if ((state == PTW_REQ || state == PTW_WAIT) && bus.io_invalidate) kill_q <= 1'b1;
      else if (state == REFILL || state == IDLE)                       kill_q <= 1'b0;
    end
  end

`ifdef L2_TLB_PERF_CNT_EN
  // Saturating lookup hit/miss counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else begin
      if (lookup_hit_evt && perf_hit_cnt != '1)   perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      if (lookup_miss_evt && perf_miss_cnt != '1) perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule
